// File: rtl/i2c_sram_master_if.sv
// Command/response and I2C pin bundle between a host and the i2c_sram_master.
// The master modport is the DUT side; the slave modport is the host/bench side.
interface i2c_sram_master_if;
  logic        start;
  logic        rw;
  logic [6:0]  dev_addr;
  logic [7:0]  mem_addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        busy;
  logic        done;
  logic        ack_error;
  logic        scl;
  logic        sda_o;
  logic        sda_oe;
  logic        sda_i;

  modport master (
    input  start, rw, dev_addr, mem_addr, wdata, sda_i,
    output rdata, busy, done, ack_error, scl, sda_o, sda_oe
  );

  modport slave (
    output start, rw, dev_addr, mem_addr, wdata, sda_i,
    input  rdata, busy, done, ack_error, scl, sda_o, sda_oe
  );
endinterface

// File: rtl/i2c_sram_master.sv
// I2C bus master for the i2c_sram_embedded slave: one fixed 36-slot frame per
// command (dev+rw, mem addr, two data bytes), with NACK abort to STOP.
module i2c_sram_master #(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  i2c_sram_master_if.master bus
);

  localparam int             QW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [QW-1:0]  QMAX = QW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV, S_ACK_DEV, S_MEM, S_ACK_MEM,
    S_WR_HI, S_ACK_WH, S_WR_LO, S_ACK_WL,
    S_RD_HI, S_MACK, S_RD_LO, S_MNACK, S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [QW-1:0]  qcnt_q, qcnt_d;
  logic [1:0]     qtr_q, qtr_d;
  logic [2:0]     bcnt_q, bcnt_d;
  logic           rw_q, rw_d;
  logic [6:0]     dev_q, dev_d;
  logic [7:0]     mem_q, mem_d;
  logic [15:0]    wdata_q, wdata_d;
  logic           samp_q, samp_d;
  logic [15:0]    rdsh_q, rdsh_d;
  logic [15:0]    rdata_q, rdata_d;
  logic           ackerr_q, ackerr_d;
  logic           done_q, done_d;

  logic           q_last, slot_end, samp_tick, bit_scl;
  logic [7:0]     tx_byte;
  logic           scl_c, sda_c, oe_c;

  assign q_last    = (qcnt_q == QMAX);
  assign slot_end  = q_last && (qtr_q == 2'd3);
  // SDA is sampled on the final clk of the first SCL-high quarter
  assign samp_tick = q_last && (qtr_q == 2'd1);
  assign bit_scl   = qtr_q[0] ^ qtr_q[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      qcnt_q   <= '0;
      qtr_q    <= 2'd0;
      bcnt_q   <= 3'd7;
      rw_q     <= 1'b0;
      dev_q    <= 7'd0;
      mem_q    <= 8'd0;
      wdata_q  <= 16'd0;
      samp_q   <= 1'b1;
      rdsh_q   <= 16'd0;
      rdata_q  <= 16'd0;
      ackerr_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      qtr_q    <= qtr_d;
      bcnt_q   <= bcnt_d;
      rw_q     <= rw_d;
      dev_q    <= dev_d;
      mem_q    <= mem_d;
      wdata_q  <= wdata_d;
      samp_q   <= samp_d;
      rdsh_q   <= rdsh_d;
      rdata_q  <= rdata_d;
      ackerr_q <= ackerr_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    qtr_d    = qtr_q;
    bcnt_d   = bcnt_q;
    rw_d     = rw_q;
    dev_d    = dev_q;
    mem_d    = mem_q;
    wdata_d  = wdata_q;
    samp_d   = samp_q;
    rdsh_d   = rdsh_q;
    rdata_d  = rdata_q;
    ackerr_d = ackerr_q;
    done_d   = 1'b0;

    if (state_q != S_IDLE) begin
      qcnt_d = q_last ? '0 : qcnt_q + 1'b1;
      if (q_last) qtr_d = qtr_q + 1'b1;
    end

    if (samp_tick) begin
      samp_d = bus.sda_i;
      if (state_q == S_RD_HI || state_q == S_RD_LO)
        rdsh_d = {rdsh_q[14:0], bus.sda_i};
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rw_d     = bus.rw;
          dev_d    = bus.dev_addr;
          mem_d    = bus.mem_addr;
          wdata_d  = bus.wdata;
          ackerr_d = 1'b0;
          qcnt_d   = '0;
          qtr_d    = 2'd0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (slot_end) begin
          bcnt_d  = 3'd7;
          state_d = S_DEV;
        end
      end
      S_DEV, S_MEM, S_WR_HI, S_WR_LO, S_RD_HI, S_RD_LO: begin
        if (slot_end) begin
          bcnt_d = bcnt_q - 3'd1;
          if (bcnt_q == 3'd0) begin
            case (state_q)
              S_DEV:   state_d = S_ACK_DEV;
              S_MEM:   state_d = S_ACK_MEM;
              S_WR_HI: state_d = S_ACK_WH;
              S_WR_LO: state_d = S_ACK_WL;
              S_RD_HI: state_d = S_MACK;
              default: state_d = S_MNACK;
            endcase
          end
        end
      end
      S_ACK_DEV, S_ACK_MEM, S_ACK_WH, S_ACK_WL: begin
        if (slot_end) begin
          bcnt_d = 3'd7;
          if (samp_q) begin
            ackerr_d = 1'b1;
            state_d  = S_STOP;
          end else begin
            case (state_q)
              S_ACK_DEV: state_d = S_MEM;
              S_ACK_MEM: state_d = rw_q ? S_RD_HI : S_WR_HI;
              S_ACK_WH:  state_d = S_WR_LO;
              default:   state_d = S_STOP;
            endcase
          end
        end
      end
      S_MACK: begin
        if (slot_end) begin
          bcnt_d  = 3'd7;
          state_d = S_RD_LO;
        end
      end
      S_MNACK: begin
        if (slot_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (slot_end) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          // a read that reached STOP without a NACK shifted in all 16 bits
          if (rw_q && !ackerr_q) rdata_d = rdsh_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_byte = 8'hFF;
    case (state_q)
      S_DEV:   tx_byte = {dev_q, rw_q};
      S_MEM:   tx_byte = mem_q;
      S_WR_HI: tx_byte = wdata_q[15:8];
      S_WR_LO: tx_byte = wdata_q[7:0];
      default: tx_byte = 8'hFF;
    endcase
  end

  // Pin levels are decoded straight from registered state so an async reset
  // releases the bus in the same cycle.
  always_comb begin
    scl_c = 1'b1;
    sda_c = 1'b1;
    oe_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        scl_c = 1'b1;
      end
      S_START: begin
        oe_c  = 1'b1;
        sda_c = (qtr_q == 2'd0);
        scl_c = (qtr_q != 2'd3);
      end
      S_STOP: begin
        oe_c  = 1'b1;
        sda_c = qtr_q[1];
        scl_c = (qtr_q != 2'd0);
      end
      S_DEV, S_MEM, S_WR_HI, S_WR_LO: begin
        oe_c  = 1'b1;
        sda_c = tx_byte[bcnt_q];
        scl_c = bit_scl;
      end
      S_MACK: begin
        oe_c  = 1'b1;
        sda_c = 1'b0;
        scl_c = bit_scl;
      end
      S_MNACK: begin
        oe_c  = 1'b1;
        sda_c = 1'b1;
        scl_c = bit_scl;
      end
      default: begin
        scl_c = bit_scl;
      end
    endcase
  end

  assign bus.scl       = scl_c;
  assign bus.sda_o     = sda_c;
  assign bus.sda_oe    = oe_c;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.ack_error = ackerr_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_i2c_sram_master.sv
// Directed bench for i2c_sram_master against a behavioural i2c_sram slave
// (device 0x3C, 256 x 16-bit words) on an open-drain SDA line.
module tb_i2c_sram_master;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   ntests = 0;
  int   nfail  = 0;

  i2c_sram_master_if bus ();

  i2c_sram_master #(.CLK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // ---------------- slave model ----------------
  logic        s_sda  = 1'b1;
  logic        srst   = 1'b1;
  logic        s_act  = 1'b0;
  int          s_bit  = 0;
  int          s_byte = 0;
  logic        s_rd   = 1'b0;
  logic [7:0]  s_sh   = 8'h00;
  logic [7:0]  s_addr = 8'h00;
  logic [7:0]  s_hi   = 8'h00;
  logic [15:0] s_rdat = 16'h0000;
  logic        s_mack, s_mnack;
  int          s_stops = 0;
  logic [15:0] smem [256];

  wire sda_w = (bus.sda_oe ? bus.sda_o : 1'b1) & s_sda;
  assign bus.sda_i = sda_w;

  always @(negedge sda_w) begin
    if (bus.scl === 1'b1 && !srst) begin
      s_act = 1'b1; s_bit = -1; s_byte = 0; s_rd = 1'b0; s_sda = 1'b1;
      s_mack = 1'bx; s_mnack = 1'bx;
    end
  end

  always @(posedge sda_w) begin
    if (bus.scl === 1'b1 && !srst) begin
      s_stops++;
      s_act = 1'b0;
    end
  end

  always @(posedge bus.scl) begin
    if (s_act && !srst) begin
      if (s_bit >= 0 && s_bit < 8) begin
        if (!(s_rd && s_byte >= 2)) s_sh = {s_sh[6:0], sda_w};
      end else if (s_bit == 8 && s_rd && s_byte == 2) s_mack = sda_w;
      else if (s_bit == 8 && s_rd && s_byte == 3) s_mnack = sda_w;
    end
  end

  always @(negedge bus.scl) begin
    if (s_act && !srst) begin
      if (s_bit < 8) begin
        s_bit++;
        if (s_bit == 8) begin
          if (s_rd && s_byte >= 2) s_sda = 1'b1;
          else begin
            case (s_byte)
              0: if (s_sh[7:1] == 7'h3C) begin s_rd = s_sh[0]; s_sda = 1'b0; end
                 else s_act = 1'b0;
              1: begin s_addr = s_sh; s_sda = 1'b0; end
              2: begin s_hi = s_sh; s_sda = 1'b0; end
              default: begin smem[s_addr] = {s_hi, s_sh}; s_sda = 1'b0; end
            endcase
          end
        end else if (s_rd && s_byte >= 2 && s_bit >= 1)
          s_sda = s_rdat[((s_byte == 2) ? 15 : 7) - s_bit];
      end else begin
        s_bit = 0; s_byte++; s_sda = 1'b1;
        if (s_rd && s_byte == 2) begin s_rdat = smem[s_addr]; s_sda = s_rdat[15]; end
        else if (s_rd && s_byte == 3) s_sda = s_rdat[7];
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic r, input logic [6:0] d,
                         input logic [7:0] a, input logic [15:0] w, input bit poke,
                         output int lat);
    @(negedge clk);
    bus.rw = r; bus.dev_addr = d; bus.mem_addr = a; bus.wdata = w; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1);
    chk({tag, "_ackerr_clr"}, bus.ack_error, 0);
    lat = 0;
    while (lat < 3000) begin
      @(posedge clk); #1;
      lat++;
      if (poke && lat == 100) begin
        bus.start = 1'b1; bus.wdata = 16'hFFFF; bus.mem_addr = 8'h00; bus.rw = 1'b1;
      end
      if (poke && lat == 101) bus.start = 1'b0;
      if (bus.done) break;
    end
    chk({tag, "_busy_end"}, bus.busy, 0);
    chk({tag, "_oe_end"}, bus.sda_oe, 0);
    @(posedge clk); #1;
    chk({tag, "_done_1clk"}, bus.done, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int stops0;
    for (int i = 0; i < 256; i++) smem[i] = 16'h0000;
    bus.start = 1'b0; bus.rw = 1'b0; bus.dev_addr = 7'h00;
    bus.mem_addr = 8'h00; bus.wdata = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_scl", bus.scl, 1);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_sda_o", bus.sda_o, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ack_error", bus.ack_error, 0);
    chk("rst_rdata", bus.rdata, 0);
    @(negedge clk); reset = 1'b1; srst = 1'b0;
    repeat (2) @(posedge clk);

    // write 0x5093 -> 0x7C
    run_cmd("t1_wr", 1'b0, 7'h3C, 8'h7C, 16'h5093, 1'b0, lat);
    chk("t1_latency", lat, 608);
    chk("t1_ack_error", bus.ack_error, 0);
    chk("t1_mem", smem[8'h7C], 16'h5093);

    // read back
    run_cmd("t2_rd", 1'b1, 7'h3C, 8'h7C, 16'h0000, 1'b0, lat);
    chk("t2_latency", lat, 608);
    chk("t2_rdata", bus.rdata, 16'h5093);
    chk("t2_mack", s_mack, 0);
    chk("t2_mnack", s_mnack, 1);
    chk("t2_ack_error", bus.ack_error, 0);

    // overwrite and read again
    run_cmd("t3_wr", 1'b0, 7'h3C, 8'h7C, 16'h04D2, 1'b0, lat);
    chk("t3_mem", smem[8'h7C], 16'h04D2);
    run_cmd("t3_rd", 1'b1, 7'h3C, 8'h7C, 16'h0000, 1'b0, lat);
    chk("t3_rdata", bus.rdata, 16'h04D2);
    chk("t3_latency", lat, 608);

    // wrong device address: NACK on the first ACK slot, short frame
    stops0 = s_stops;
    run_cmd("t4_nack", 1'b1, 7'h3D, 8'h7C, 16'h0000, 1'b0, lat);
    chk("t4_latency", lat, 176);
    chk("t4_ack_error", bus.ack_error, 1);
    chk("t4_rdata_hold", bus.rdata, 16'h04D2);
    chk("t4_stop_seen", s_stops - stops0, 1);

    // start pulsed mid-transfer with different operands is ignored
    run_cmd("t5_poke", 1'b0, 7'h3C, 8'h7C, 16'h5093, 1'b1, lat);
    chk("t5_latency", lat, 608);
    chk("t5_mem", smem[8'h7C], 16'h5093);
    chk("t5_mem0", smem[8'h00], 16'h0000);
    chk("t5_ack_error", bus.ack_error, 0);

    // reset in the middle of WR_LO
    @(negedge clk);
    bus.rw = 1'b0; bus.dev_addr = 7'h3C; bus.mem_addr = 8'h7C; bus.wdata = 16'hBEEF;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (468) @(posedge clk);
    #3;
    srst = 1'b1;
    reset = 1'b0;
    #1;
    chk("t6_scl", bus.scl, 1);
    chk("t6_sda_oe", bus.sda_oe, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_rdata_clr", bus.rdata, 0);
    chk("t6_mem_untouched", smem[8'h7C], 16'h5093);
    s_act = 1'b0; s_sda = 1'b1;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); srst = 1'b0;
    repeat (2) @(posedge clk);

    run_cmd("t6_wr", 1'b0, 7'h3C, 8'h7C, 16'h1234, 1'b0, lat);
    chk("t6_wr_latency", lat, 608);
    chk("t6_mem", smem[8'h7C], 16'h1234);
    run_cmd("t6_rd", 1'b1, 7'h3C, 8'h7C, 16'h0000, 1'b0, lat);
    chk("t6_rdata", bus.rdata, 16'h1234);
    chk("t6_ack_error", bus.ack_error, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
